// File: rtl/fifo_pkg.sv
// fifo_pkg: default FIFO geometry and the pointer-width helper shared by param_fifo and fifo_mem
package fifo_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: unreset word storage, one write port (we/waddr/wdata) and one registered read port (re/raddr -> q, holds when re=0)
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] q
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/param_fifo.sv
// param_fifo: sync FIFO (clock/reset; write_en/data_in; read_en -> data_out/data_valid next cycle; full/empty/almost flags, count; sticky overflow/underflow cleared by err_clr)
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         write_en,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         read_en,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         data_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [ptr_width(DEPTH)-1:0]  count,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         err_clr
);
  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem_q;
  logic rd_ok, wr_ok, out_ok;
  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 4 || AE_LEVEL >= AF_LEVEL) begin : g_bad_params
    $error("param_fifo: DEPTH must be a power of two >= 4 and AE_LEVEL < AF_LEVEL");
  end
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr[AW-1:0] == rd_ptr[AW-1:0] && wr_ptr[AW] != rd_ptr[AW];
  assign rd_ok = read_en & ~empty;
  assign wr_ok = write_en & (~full | rd_ok);
  assign almost_full = count >= PW'(AF_LEVEL);
  assign almost_empty = count <= PW'(AE_LEVEL);
  assign data_out = out_ok ? mem_q : '0;
  fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clock),
    .we    (wr_ok & ~reset),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (data_in),
    .re    (rd_ok & ~reset),
    .raddr (rd_ptr[AW-1:0]),
    .q     (mem_q)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      data_valid <= 1'b0;
      out_ok <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ok ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr <= rd_ok ? rd_ptr + PW'(1) : rd_ptr;
      count <= count + PW'(wr_ok) - PW'(rd_ok);
      data_valid <= rd_ok;
      out_ok <= out_ok | rd_ok;
      overflow <= (write_en & ~wr_ok) | (overflow & ~err_clr);
      underflow <= (read_en & empty) | (underflow & ~err_clr);
    end
  end
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: queue-model scoreboard plus directed literal checks for param_fifo (DEPTH=8, AF=6, AE=2)
module tb_param_fifo;
  logic clock = 1'b0, reset = 1'b1, write_en = 1'b0, read_en = 1'b0, err_clr = 1'b0;
  logic [7:0] data_in = 8'h00, data_out;
  logic data_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;
  int errors = 0, checks = 0;
  logic [7:0] q [$];
  logic [7:0] m_dout = 8'h00;
  logic m_dv = 1'b0, m_ovf = 1'b0, m_unf = 1'b0, armed = 1'b0;

  param_fifo #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clock(clock), .reset(reset), .write_en(write_en), .data_in(data_in), .read_en(read_en),
    .data_out(data_out), .data_valid(data_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    int n;
    logic rd, wr;
    n = q.size();
    if (reset) begin
      q.delete();
      m_dout = 8'h00;
      m_dv = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      armed = 1'b1;
    end else begin
      rd = read_en && n > 0;
      wr = write_en && (n < 8 || rd);
      m_dv = rd;
      if (rd) m_dout = q.pop_front();
      if (wr) q.push_back(data_in);
      m_ovf = (write_en && !wr) || (m_ovf && !err_clr);
      m_unf = (read_en && n == 0) || (m_unf && !err_clr);
    end
    #1;
    if (armed) begin
      n = q.size();
      chk("m_count", int'(count), n);
      chk("m_full", int'(full), int'(n == 8));
      chk("m_empty", int'(empty), int'(n == 0));
      chk("m_afull", int'(almost_full), int'(n >= 6));
      chk("m_aempty", int'(almost_empty), int'(n <= 2));
      chk("m_dv", int'(data_valid), int'(m_dv));
      chk("m_dout", int'(data_out), int'(m_dout));
      chk("m_ovf", int'(overflow), int'(m_ovf));
      chk("m_unf", int'(underflow), int'(m_unf));
    end
  end

  task automatic cyc(input logic we, input logic [7:0] din, input logic re, input logic clr, input logic rst);
    write_en = we;
    data_in = din;
    read_en = re;
    err_clr = clr;
    reset = rst;
    @(posedge clock);
    #2;
  endtask

  task automatic fill();
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_aempty", int'(almost_empty), 1);
    chk("rst_dout", int'(data_out), 0);
    chk("rst_dv", int'(data_valid), 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      chk("fill_count", int'(count), i + 1);
      chk("fill_afull", int'(almost_full), int'(i >= 5));
      chk("fill_full", int'(full), int'(i == 7));
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("drain_dout", int'(data_out), i);
      chk("drain_dv", int'(data_valid), 1);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("drain_empty", int'(empty), 1);
    chk("hold_dv", int'(data_valid), 0);
    chk("hold_dout", int'(data_out), 8'h07);
    fill();
    cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_count", int'(count), 8);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("ovf_dout", int'(data_out), i);
    end
    chk("ovf_sticky", int'(overflow), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("ovf_clr", int'(overflow), 0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("unf_set", int'(underflow), 1);
    chk("unf_count", int'(count), 1);
    chk("unf_dv", int'(data_valid), 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("unf_dout", int'(data_out), 8'h55);
    chk("unf_dv2", int'(data_valid), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("clr_vs_new_err", int'(underflow), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("unf_clr", int'(underflow), 0);
    fill();
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, k == 0 ? 8'h99 : 8'(8'hA0 + k), 1'b1, 1'b0, 1'b0);
      chk("wrap_count", int'(count), 8);
      chk("wrap_dout", int'(data_out), k < 8 ? k : (k == 8 ? 8'h99 : 8'hA0 + k - 8));
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_unf", int'(underflow), 0);
    chk("mid_rst_dout", int'(data_out), 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("post_rst_unf", int'(underflow), 1);
    chk("post_rst_dv", int'(data_valid), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
